// File: rtl/spi_req_arbiter.sv
// rtl/spi_req_arbiter.sv - round-robin arbiter sharing one SPI master between requesters
module spi_req_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 12,
   parameter int TIMEOUT = 1024
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   output logic [NUM_REQ-1:0]        gnt,
   output logic [NUM_REQ-1:0]        rsp_valid,
   output logic [DATA_W-1:0]         rsp_data,
   output logic                      rsp_err,
   output logic                      busy,
   output logic                      m_newd,
   output logic [DATA_W-1:0]         m_din,
   input  logic [DATA_W-1:0]         m_dout,
   input  logic                      m_done,
   input  logic                      m_sclk
);

   localparam int PW = $clog2(NUM_REQ);
   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [PW-1:0]      LAST    = PW'(NUM_REQ - 1);
   localparam logic [CW-1:0]      CNT_LIM = CW'(TIMEOUT - 1);
   localparam logic [CW-1:0]      CNT_MAX = CW'(TIMEOUT);
   localparam logic [NUM_REQ-1:0] ONE     = NUM_REQ'(1);

   typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, WAIT = 2'd2} state_t;

   state_t              state, state_nx;
   logic [PW-1:0]       ptr, ptr_nx;
   logic [PW-1:0]       owner, owner_nx;
   logic [CW-1:0]       cnt, cnt_nx;
   logic                m_sclk_q, m_done_q;
   logic                sclk_rise, done_rise, tmo;
   logic [PW-1:0]       sel;
   logic [NUM_REQ-1:0]  gnt_nx, rsp_valid_nx;
   logic [DATA_W-1:0]   rsp_data_nx, m_din_nx;
   logic                rsp_err_nx, busy_nx, m_newd_nx;

   assign sclk_rise = m_sclk & ~m_sclk_q;
   assign done_rise = m_done & ~m_done_q;
   // the counter saturates so a late sclk edge in START still leads to an abort in WAIT
   assign tmo       = (cnt >= CNT_LIM);

   // first set request bit at or above the pointer, wrapping around
   function automatic logic [PW-1:0] rr_pick(input logic [NUM_REQ-1:0] r, input logic [PW-1:0] p);
      logic [PW-1:0] k;
      logic [PW:0]   sum;
      k = p;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         sum = {1'b0, p} + (PW+1)'(i);
         if (sum >= (PW+1)'(NUM_REQ)) begin
            sum = sum - (PW+1)'(NUM_REQ);
         end
         if (r[sum[PW-1:0]]) begin
            k = sum[PW-1:0];
         end
      end
      return k;
   endfunction

   assign sel = rr_pick(req, ptr);

   // state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // next-state logic
   always_comb begin
      state_nx = state;
      case (state)
         IDLE: begin
            if (req != '0) begin
               state_nx = START;
            end
         end
         START: begin
            if (sclk_rise) begin
               state_nx = WAIT;
            end else if (tmo) begin
               state_nx = IDLE;
            end
         end
         WAIT: begin
            if (done_rise || tmo) begin
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // next values of the registered outputs and transaction bookkeeping
   always_comb begin
      gnt_nx       = '0;
      rsp_valid_nx = '0;
      rsp_data_nx  = rsp_data;
      rsp_err_nx   = rsp_err;
      m_newd_nx    = m_newd;
      m_din_nx     = m_din;
      owner_nx     = owner;
      ptr_nx       = ptr;
      cnt_nx       = cnt;
      if (state != IDLE && cnt != CNT_MAX) begin
         cnt_nx = cnt + CW'(1);
      end
      case (state)
         IDLE: begin
            if (req != '0) begin
               gnt_nx    = ONE << sel;
               m_din_nx  = req_data[int'(sel)*DATA_W +: DATA_W];
               m_newd_nx = 1'b1;
               owner_nx  = sel;
               ptr_nx    = (sel == LAST) ? '0 : sel + PW'(1);
               cnt_nx    = '0;
            end
         end
         START: begin
            if (sclk_rise) begin
               m_newd_nx = 1'b0;
            end else if (tmo) begin
               m_newd_nx    = 1'b0;
               rsp_valid_nx = ONE << owner;
               rsp_err_nx   = 1'b1;
               rsp_data_nx  = '0;
            end
         end
         WAIT: begin
            if (done_rise) begin
               rsp_valid_nx = ONE << owner;
               rsp_err_nx   = 1'b0;
               rsp_data_nx  = m_dout;
            end else if (tmo) begin
               m_newd_nx    = 1'b0;
               rsp_valid_nx = ONE << owner;
               rsp_err_nx   = 1'b1;
               rsp_data_nx  = '0;
            end
         end
         default: begin
            m_newd_nx = 1'b0;
         end
      endcase
      busy_nx = (state_nx != IDLE);
   end

   // output and bookkeeping registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         gnt       <= '0;
         rsp_valid <= '0;
         rsp_data  <= '0;
         rsp_err   <= 1'b0;
         busy      <= 1'b0;
         m_newd    <= 1'b0;
         m_din     <= '0;
         owner     <= '0;
         ptr       <= '0;
         cnt       <= '0;
      end else begin
         gnt       <= gnt_nx;
         rsp_valid <= rsp_valid_nx;
         rsp_data  <= rsp_data_nx;
         rsp_err   <= rsp_err_nx;
         busy      <= busy_nx;
         m_newd    <= m_newd_nx;
         m_din     <= m_din_nx;
         owner     <= owner_nx;
         ptr       <= ptr_nx;
         cnt       <= cnt_nx;
      end
   end

   // previous-cycle samples for sclk and done edge detection
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_sclk_q <= 1'b0;
         m_done_q <= 1'b0;
      end else begin
         m_sclk_q <= m_sclk;
         m_done_q <= m_done;
      end
   end

endmodule

// File: tb/tb_spi_req_arbiter.sv
// tb/tb_spi_req_arbiter.sv - self-checking bench for spi_req_arbiter
module tb_spi_req_arbiter;

   localparam int NR = 4;
   localparam int DW = 12;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic [NR-1:0]    req = '0;
   logic [NR*DW-1:0] req_data = '0;
   logic [NR-1:0]    gnt;
   logic [NR-1:0]    rsp_valid;
   logic [DW-1:0]    rsp_data;
   logic             rsp_err;
   logic             busy;
   logic             m_newd;
   logic [DW-1:0]    m_din;
   logic [DW-1:0]    m_dout = '0;
   logic             m_done = 1'b0;
   logic             m_sclk = 1'b0;

   spi_req_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .TIMEOUT(64)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .req_data  (req_data),
      .gnt       (gnt),
      .rsp_valid (rsp_valid),
      .rsp_data  (rsp_data),
      .rsp_err   (rsp_err),
      .busy      (busy),
      .m_newd    (m_newd),
      .m_din     (m_din),
      .m_dout    (m_dout),
      .m_done    (m_done),
      .m_sclk    (m_sclk)
   );

   always #5 clk = ~clk;

   typedef struct {
      int            k;
      logic [DW-1:0] data;
      logic          err;
   } exp_t;

   typedef struct {
      logic [NR-1:0]    req;
      logic [NR*DW-1:0] data;
      int               k;
   } vec_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   rsp_pulses = 0;
   logic busy_prev = 1'b0;

   task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h", name, act, exp);
      end
   endtask

   // response scoreboard and grant-while-busy monitor
   always @(negedge clk) begin
      exp_t e;
      if (rst && rsp_valid != '0) begin
         rsp_pulses++;
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rsp_unexpected got %b want none", rsp_valid);
         end else begin
            e = sb.pop_front();
            check("rsp_valid", 48'(rsp_valid), 48'(4'b0001 << e.k));
            check("rsp_data", 48'(rsp_data), 48'(e.data));
            check("rsp_err", 48'(rsp_err), 48'(e.err));
         end
      end
      if (rst && gnt != '0) begin
         check("gnt_while_busy", 48'(busy_prev), 48'(0));
      end
      busy_prev = busy;
   end

   // raise req, wait for the grant, record the expected response, drop req
   task automatic issue(input logic [NR-1:0] mask, input logic [NR*DW-1:0] data, input int k, input logic err);
      logic [DW-1:0] w;
      exp_t          e;
      int            n;
      w = DW'(data >> (k * DW));
      req_data = data;
      req = mask;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (gnt == '0 && n < 50);
      check("gnt", 48'(gnt), 48'(4'b0001 << k));
      check("gnt_latency", 48'(n), 48'(1));
      check("newd_at_gnt", 48'(m_newd), 48'(1));
      check("m_din", 48'(m_din), 48'(w));
      check("busy_at_gnt", 48'(busy), 48'(1));
      e.k = k;
      e.data = err ? '0 : w;
      e.err = err;
      sb.push_back(e);
      req = '0;
   endtask

   task automatic sclk_phase(input int delay);
      repeat (delay) @(negedge clk);
      check("newd_hold", 48'(m_newd), 48'(1));
      m_sclk = 1'b1;
      @(negedge clk);
      check("newd_drop", 48'(m_newd), 48'(0));
      check("busy_wait", 48'(busy), 48'(1));
      m_sclk = 1'b0;
   endtask

   task automatic done_phase(input int len);
      m_dout = m_din;
      m_done = 1'b1;
      repeat (len) @(negedge clk);
      m_done = 1'b0;
      repeat (2) @(negedge clk);
      check("busy_idle", 48'(busy), 48'(0));
      check("sb_drained", 48'(sb.size()), 48'(0));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs[10];
      int   n;
      int   pulses0;
      vecs[0] = '{4'b1111, 48'h123_456_789_ABC, 0};
      vecs[1] = '{4'b1111, 48'h111_222_333_444, 1};
      vecs[2] = '{4'b1111, 48'hFED_CBA_987_654, 2};
      vecs[3] = '{4'b1111, 48'h800_001_7FF_FFF, 3};
      vecs[4] = '{4'b1111, 48'h0F0_E1D_2C3_B4A, 0};
      vecs[5] = '{4'b1111, 48'h555_AAA_555_AAA, 1};
      vecs[6] = '{4'b0100, 48'h000_A5C_000_000, 2};
      vecs[7] = '{4'b0001, 48'h000_000_000_3C3, 0};
      vecs[8] = '{4'b1001, 48'h9E7_000_000_001, 3};
      vecs[9] = '{4'b1001, 48'h9E7_000_000_001, 0};

      // reset state
      repeat (3) @(negedge clk);
      check("rst_gnt", 48'(gnt), 48'(0));
      check("rst_rsp_valid", 48'(rsp_valid), 48'(0));
      check("rst_busy", 48'(busy), 48'(0));
      check("rst_newd", 48'(m_newd), 48'(0));
      check("rst_m_din", 48'(m_din), 48'(0));
      check("rst_rsp_data", 48'(rsp_data), 48'(0));
      check("rst_rsp_err", 48'(rsp_err), 48'(0));
      rst = 1'b1;
      @(negedge clk);

      // fairness, single loopback request, pointer wrap
      for (int i = 0; i < 10; i++) begin
         issue(vecs[i].req, vecs[i].data, vecs[i].k, 1'b0);
         sclk_phase(1 + (i % 3));
         done_phase(1 + (i % 2));
      end

      // stalled master: abort 64 cycles after grant
      issue(4'b0010, 48'h000_000_3C3_000, 1, 1'b1);
      n = 0;
      while (rsp_valid == '0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("tmo_latency", 48'(n), 48'(64));
      check("tmo_newd", 48'(m_newd), 48'(0));
      check("tmo_busy", 48'(busy), 48'(0));
      @(negedge clk);
      issue(4'b1000, 48'h6B2_000_000_000, 3, 1'b0);
      sclk_phase(1);
      done_phase(1);

      // done held high: one response; done already high in next WAIT: no completion
      pulses0 = rsp_pulses;
      issue(4'b0001, 48'h000_000_000_D0E, 0, 1'b0);
      sclk_phase(1);
      m_dout = m_din;
      m_done = 1'b1;
      repeat (5) @(negedge clk);
      check("done_held_pulses", 48'(rsp_pulses - pulses0), 48'(1));
      issue(4'b0100, 48'h000_7E1_000_000, 2, 1'b0);
      sclk_phase(1);
      repeat (5) @(negedge clk);
      check("no_stale_done", 48'(sb.size()), 48'(1));
      check("stale_busy", 48'(busy), 48'(1));
      m_done = 1'b0;
      @(negedge clk);
      done_phase(1);

      // reset during WAIT drops the transaction and the pointer
      issue(4'b0010, 48'h000_000_4D4_000, 1, 1'b0);
      sclk_phase(1);
      #2 rst = 1'b0;
      #1;
      check("arst_busy", 48'(busy), 48'(0));
      check("arst_newd", 48'(m_newd), 48'(0));
      check("arst_gnt", 48'(gnt), 48'(0));
      check("arst_rsp_valid", 48'(rsp_valid), 48'(0));
      check("arst_rsp_data", 48'(rsp_data), 48'(0));
      sb.delete();
      repeat (2) @(negedge clk);
      rst = 1'b1;
      issue(4'b0110, 48'h000_321_CBA_000, 1, 1'b0);
      sclk_phase(1);
      done_phase(1);

      check("final_sb_empty", 48'(sb.size()), 48'(0));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
